// File: rtl/channel_out_pkg.sv
// -----------------------------------------------------------------------------
// channel_out_pkg
// Shared types and constants for the per-channel NeoPixel waveform generator.
//   state_e    : waveform FSM states
//   timing_t   : latched T0H/T0L/T1H/T1L phase lengths (clocks minus 1)
//   phase_len  : picks the phase length for a given bit value and phase
// -----------------------------------------------------------------------------
package channel_out_pkg;

  localparam int LED_BITS  = 24;                 // colour bits sent per LED
  localparam int BIT_IDX_W = $clog2(LED_BITS);   // width of the bit index
  localparam int TIME_W    = 8;                  // timing-register width

  typedef logic [TIME_W-1:0]    time_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_HOLD
  } state_e;

  typedef struct packed {
    time_t t0h;
    time_t t0l;
    time_t t1h;
    time_t t1l;
  } timing_t;

  function automatic time_t phase_len(timing_t t, logic bit_val, logic high_phase);
    if (high_phase) return bit_val ? t.t1h : t.t0h;
    return bit_val ? t.t1l : t.t0l;
  endfunction

endpackage

// File: rtl/channel_out_phase_cnt.sv
// -----------------------------------------------------------------------------
// channel_phase_cnt
// Loadable 8-bit down-counter timing one HIGH or LOW phase. Loading value V
// makes tc_o assert V clocks later, so a phase of (V+1) clocks ends on the
// cycle tc_o is high. The counter parks at zero.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : load load_val_i (takes priority over counting)
//   load_val_i     : phase length minus 1
//   tc_o           : terminal count (counter is zero)
// -----------------------------------------------------------------------------
module channel_phase_cnt
  import channel_out_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  load_i,
  input  time_t load_val_i,
  output logic  tc_o
);

  time_t cnt_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - time_t'(1);
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/channel_out.sv
// -----------------------------------------------------------------------------
// channel_out
// Per-channel NeoPixel waveform generator. On start_i it reads LED words
// 0..reg_chan_len_i from the channel RAM and sends bits [23:0] of each word
// MSB first as T0H/T0L/T1H/T1L coded pulses on bit_code_o. The next LED word
// is prefetched during bit 0 so LEDs follow each other with no gap.
// Optional build macro RESET_CODE_EN adds a HOLD state that keeps the line
// low (busy) for RESET_CYCLES clocks before done_o.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   start_i                 : frame start strobe (ignored while busy/done)
//   reg_t0h/t0l/t1h/t1l_*_i : phase lengths in clocks minus 1
//   reg_chan_len_i          : index of the last LED
//   ram_rd_en_o/addr_o      : one-cycle RAM read request
//   ram_rd_data_i           : RAM data, valid one cycle after the request
//   bit_code_o              : coded serial output, idle low
//   busy_o, done_o          : frame in progress, end-of-frame pulse
// -----------------------------------------------------------------------------
module channel_out
  import channel_out_pkg::*;
#(
  parameter int RESET_CYCLES = 16000,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [7:0]        reg_t0h_time_i,
  input  logic [7:0]        reg_t0l_time_i,
  input  logic [7:0]        reg_t1h_time_i,
  input  logic [7:0]        reg_t1l_time_i,
  input  logic [7:0]        reg_chan_len_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i,
  output logic              bit_code_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e              state_q, state_d;
  timing_t             timing_q, timing_d;
  logic [ADDR_W-1:0]   len_q, len_d, led_q, led_d, rd_addr_q, rd_addr_d;
  logic [LED_BITS-1:0] shift_q, shift_d, shadow_q, shadow_d, next_word;
  bit_idx_t            bit_idx_q, bit_idx_d;
  logic                rd_en_q, rd_en_d, rd_pend_q;
  logic                bit_code_q, bit_code_d, busy_q, busy_d, done_q, done_d;
  logic                phase_load, phase_tc;
  time_t               phase_val;

  // Colour byte layout keeps only [23:0]; the top byte is don't-care.
  logic unused_data_hi;
  assign unused_data_hi = ^ram_rd_data_i[DATA_W-1:LED_BITS];

`ifdef RESET_CODE_EN
  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`else
  logic [31:0] unused_reset_cycles;
  assign unused_reset_cycles = 32'(RESET_CYCLES);
`endif

  channel_phase_cnt u_phase_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .tc_o       (phase_tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    timing_d   = timing_q;
    len_d      = len_q;
    led_d      = led_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = 1'b0;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    bit_code_d = bit_code_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    phase_load = 1'b0;
    phase_val  = '0;
    // Prefetched data may arrive on the very cycle the last LOW ends
    // (1-clock phases), so bypass the shadow register while it is in flight.
    next_word  = rd_pend_q ? ram_rd_data_i[LED_BITS-1:0] : shadow_q;
    shadow_d   = next_word;
`ifdef RESET_CODE_EN
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // The done cycle already shows busy_o low but must not start a frame.
        if (start_i && !done_q) begin
          timing_d  = '{t0h: reg_t0h_time_i, t0l: reg_t0l_time_i,
                        t1h: reg_t1h_time_i, t1l: reg_t1l_time_i};
          len_d     = ADDR_W'(reg_chan_len_i);
          led_d     = '0;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d    = ram_rd_data_i[LED_BITS-1:0];
        bit_idx_d  = bit_idx_t'(LED_BITS - 1);
        bit_code_d = 1'b1;
        phase_load = 1'b1;
        phase_val  = phase_len(timing_q, ram_rd_data_i[LED_BITS-1], 1'b1);
        state_d    = ST_HIGH;
      end
      ST_HIGH: begin
        if (phase_tc) begin
          bit_code_d = 1'b0;
          phase_load = 1'b1;
          phase_val  = phase_len(timing_q, shift_q[LED_BITS-1], 1'b0);
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_tc) begin
          if (bit_idx_q != '0) begin
            shift_d    = {shift_q[LED_BITS-2:0], 1'b0};
            bit_idx_d  = bit_idx_q - bit_idx_t'(1);
            bit_code_d = 1'b1;
            phase_load = 1'b1;
            phase_val  = phase_len(timing_q, shift_q[LED_BITS-2], 1'b1);
            state_d    = ST_HIGH;
            // Entering bit 0: request the next LED so it is ready at the boundary.
            if (bit_idx_q == bit_idx_t'(1) && led_q != len_q) begin
              rd_en_d   = 1'b1;
              rd_addr_d = led_q + ADDR_W'(1);
            end
          end else if (led_q != len_q) begin
            shift_d    = next_word;
            bit_idx_d  = bit_idx_t'(LED_BITS - 1);
            led_d      = led_q + ADDR_W'(1);
            bit_code_d = 1'b1;
            phase_load = 1'b1;
            phase_val  = phase_len(timing_q, next_word[LED_BITS-1], 1'b1);
            state_d    = ST_HIGH;
          end else begin
`ifdef RESET_CODE_EN
            hold_cnt_d = HOLD_W'(RESET_CYCLES - 1);
            state_d    = ST_HOLD;
`else
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
`endif
          end
        end
      end
`ifdef RESET_CODE_EN
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timing_q   <= '0;
      len_q      <= '0;
      led_q      <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      shift_q    <= '0;
      shadow_q   <= '0;
      bit_idx_q  <= '0;
      bit_code_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESET_CODE_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      timing_q   <= timing_d;
      len_q      <= len_d;
      led_q      <= led_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_en_q;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      bit_idx_q  <= bit_idx_d;
      bit_code_q <= bit_code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RESET_CODE_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign ram_rd_en_o   = rd_en_q;
  assign ram_rd_addr_o = rd_addr_q;
  assign bit_code_o    = bit_code_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
